// File: rtl/endpoint_table_pkg.sv
// rtl/endpoint_table_pkg.sv - shared opcodes, status codes, entry field offsets and entry packing
package endpoint_table_pkg;

  localparam int ENTRY_BITS = 160;

  localparam logic [1:0] OP_INSERT    = 2'd0;
  localparam logic [1:0] OP_DELETE    = 2'd1;
  localparam logic [1:0] OP_CLEAR_ALL = 2'd2;

  localparam logic [2:0] ST_OK_NEW     = 3'd0;
  localparam logic [2:0] ST_OK_UPDATED = 3'd1;
  localparam logic [2:0] ST_COLLISION  = 3'd2;
  localparam logic [2:0] ST_EVICTED    = 3'd3;
  localparam logic [2:0] ST_DELETED    = 3'd4;
  localparam logic [2:0] ST_NOT_FOUND  = 3'd5;
  localparam logic [2:0] ST_BAD_OP     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_EVAL,
    S_WRITE,
    S_CLEAR,
    S_DONE
  } state_t;

  // Fields are anchored to the MSB so the same offsets hold for any word width.
  function automatic int valid_bit(input int w);
    return w - 1;
  endfunction

  function automatic int ip_lsb(input int w);
    return w - 64;
  endfunction

  function automatic logic [ENTRY_BITS-1:0] pack_entry(input logic [31:0] ip,
                                                       input logic [47:0] dst_mac,
                                                       input logic [47:0] src_mac);
    return {1'b1, 31'b0, ip, dst_mac, src_mac};
  endfunction

endpackage

// File: rtl/endpoint_hash.sv
// rtl/endpoint_hash.sv - endpoint table index hash, shared with the lookup path
module endpoint_hash #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic [31:0]           ip,
  output logic [ADDR_WIDTH-1:0] index
);

  logic ip_unused;

  assign index     = ip[ADDR_WIDTH-1:0] ^ ip[ADDR_WIDTH+7:8];
  assign ip_unused = ^ip;

endmodule

// File: rtl/endpoint_table_writer.sv
// rtl/endpoint_table_writer.sv - insert/delete/clear writer owning endpoint BRAM port A
// Optional macro ENDPOINT_COUNT_EN: entry_count tracks valid entries (else tied to 0).
module endpoint_table_writer #(
  parameter int ADDR_WIDTH      = 11,
  parameter int BRAM_DATA_WIDTH = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic                       cmd_force,
  input  logic [31:0]                cmd_ip,
  input  logic [47:0]                cmd_dst_mac,
  input  logic [47:0]                cmd_src_mac,
  output logic                       resp_done,
  output logic [2:0]                 resp_status,
  output logic [ADDR_WIDTH-1:0]      bram_addr_a,
  output logic                       bram_en_a,
  output logic                       bram_we_a,
  output logic [BRAM_DATA_WIDTH-1:0] bram_din_a,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_dout_a,
  output logic [ADDR_WIDTH:0]        entry_count
);
  import endpoint_table_pkg::*;

  localparam int W          = BRAM_DATA_WIDTH;
  localparam int VALID_BIT  = valid_bit(W);
  localparam int IP_LSB     = ip_lsb(W);
  localparam int HDR_IP_LSB = ip_lsb(ENTRY_BITS);

  if (W < ENTRY_BITS) begin : g_width_check
    $fatal(1, "endpoint_table_writer: BRAM_DATA_WIDTH must be >= 160");
  end

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic                    force_q, force_d;
  logic [ENTRY_BITS-1:0]   hdr_q, hdr_d;
  logic [2:0]              st_q, st_d;
  logic                    ready_d, done_d, en_d, we_d;
  logic [2:0]              status_d;
  logic [ADDR_WIDTH-1:0]   addr_d, index;
  logic [W-1:0]            din_d;
  logic                    slot_valid, ip_match, dout_unused;

  endpoint_hash #(.ADDR_WIDTH(ADDR_WIDTH)) u_hash (
    .ip    (cmd_ip),
    .index (index)
  );

  assign slot_valid  = bram_dout_a[VALID_BIT];
  assign ip_match    = bram_dout_a[IP_LSB +: 32] == hdr_q[HDR_IP_LSB +: 32];
  assign dout_unused = ^bram_dout_a;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    force_d  = force_q;
    hdr_d    = hdr_q;
    st_d     = st_q;
    ready_d  = cmd_ready;
    done_d   = 1'b0;
    status_d = resp_status;
    addr_d   = bram_addr_a;
    en_d     = 1'b0;
    we_d     = 1'b0;
    din_d    = bram_din_a;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          force_d = cmd_force;
          hdr_d   = pack_entry(cmd_ip, cmd_dst_mac, cmd_src_mac);
          ready_d = 1'b0;
          case (cmd_op)
            OP_INSERT, OP_DELETE: begin
              en_d    = 1'b1;
              addr_d  = index;
              state_d = S_RD_WAIT;
            end
            OP_CLEAR_ALL: begin
              en_d    = 1'b1;
              we_d    = 1'b1;
              addr_d  = '0;
              din_d   = '0;
              state_d = S_CLEAR;
            end
            default: begin
              st_d    = ST_BAD_OP;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_RD_WAIT: state_d = S_EVAL;
      S_EVAL: begin
        state_d = S_WRITE;
        en_d    = 1'b1;
        we_d    = 1'b1;
        din_d   = W'(hdr_q) << (W - ENTRY_BITS);
        if (op_q == OP_INSERT) begin
          if (!slot_valid)   st_d = ST_OK_NEW;
          else if (ip_match) st_d = ST_OK_UPDATED;
          else if (force_q)  st_d = ST_EVICTED;
          else begin
            st_d    = ST_COLLISION;
            en_d    = 1'b0;
            we_d    = 1'b0;
            state_d = S_DONE;
          end
        end else if (slot_valid && ip_match) begin
          st_d  = ST_DELETED;
          din_d = '0;
        end else begin
          st_d    = ST_NOT_FOUND;
          en_d    = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_CLEAR: begin
        if (bram_addr_a == {ADDR_WIDTH{1'b1}}) begin
          st_d    = ST_OK_NEW;
          state_d = S_DONE;
        end else begin
          addr_d = bram_addr_a + ADDR_WIDTH'(1);
          en_d   = 1'b1;
          we_d   = 1'b1;
          din_d  = '0;
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        status_d = st_q;
        ready_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      force_q     <= 1'b0;
      hdr_q       <= '0;
      st_q        <= ST_OK_NEW;
      cmd_ready   <= 1'b1;
      resp_done   <= 1'b0;
      resp_status <= ST_OK_NEW;
      bram_addr_a <= '0;
      bram_en_a   <= 1'b0;
      bram_we_a   <= 1'b0;
      bram_din_a  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      force_q     <= force_d;
      hdr_q       <= hdr_d;
      st_q        <= st_d;
      cmd_ready   <= ready_d;
      resp_done   <= done_d;
      resp_status <= status_d;
      bram_addr_a <= addr_d;
      bram_en_a   <= en_d;
      bram_we_a   <= we_d;
      bram_din_a  <= din_d;
    end
  end

`ifdef ENDPOINT_COUNT_EN
  logic [ADDR_WIDTH:0] count_q;

  // CLEAR also reports OK_NEW, so the opcode decides before the status does.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (state_q == S_DONE) begin
      if (op_q == OP_CLEAR_ALL)      count_q <= '0;
      else if (st_q == ST_OK_NEW)    count_q <= count_q + (ADDR_WIDTH+1)'(1);
      else if (st_q == ST_DELETED)   count_q <= count_q - (ADDR_WIDTH+1)'(1);
    end
  end

  assign entry_count = count_q;
`else
  assign entry_count = '0;
`endif

endmodule

// File: tb/tb_endpoint_table_writer.sv
// tb/tb_endpoint_table_writer.sv - scoreboard bench for endpoint_table_writer with a BRAM model
module tb_endpoint_table_writer;

  localparam int AW = 11;
  localparam int W  = 256;
`ifdef ENDPOINT_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0] status;
    int         lat;
    string      name;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic          cmd_force = 1'b0;
  logic [31:0]   cmd_ip = '0;
  logic [47:0]   cmd_dst_mac = '0;
  logic [47:0]   cmd_src_mac = '0;
  logic          resp_done;
  logic [2:0]    resp_status;
  logic [AW-1:0] bram_addr_a;
  logic          bram_en_a;
  logic          bram_we_a;
  logic [W-1:0]  bram_din_a;
  logic [W-1:0]  bram_dout_a = '0;
  logic [AW:0]   entry_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int cnt_model = 0;
  resp_t resp_q[$];
  wr_t   wr_q[$];
  logic [W-1:0] mem [0:(1<<AW)-1];

  endpoint_table_writer #(.ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_force   (cmd_force),
    .cmd_ip      (cmd_ip),
    .cmd_dst_mac (cmd_dst_mac),
    .cmd_src_mac (cmd_src_mac),
    .resp_done   (resp_done),
    .resp_status (resp_status),
    .bram_addr_a (bram_addr_a),
    .bram_en_a   (bram_en_a),
    .bram_we_a   (bram_we_a),
    .bram_din_a  (bram_din_a),
    .bram_dout_a (bram_dout_a),
    .entry_count (entry_count)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en_a) begin
      if (bram_we_a) mem[bram_addr_a] <= bram_din_a;
      bram_dout_a <= mem[bram_addr_a];
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rstn && cmd_valid && cmd_ready) acc_cyc = cyc;
  end

  // Scoreboard: every write and every response must match the next queued expectation.
  always @(negedge clk) begin
    if (bram_en_a && bram_we_a) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h", bram_addr_a, bram_din_a);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        if (bram_addr_a !== w.addr || bram_din_a !== w.data) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   bram_addr_a, bram_din_a, w.addr, w.data);
        end
      end
    end
    if (resp_done) begin
      checks++;
      if (resp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: status=%0d", resp_status);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        if (resp_status !== r.status) begin
          errors++;
          $display("FAIL status %s: got %0d, expected %0d", r.name, resp_status, r.status);
        end
        checks++;
        if (cyc - acc_cyc != r.lat) begin
          errors++;
          $display("FAIL latency %s: got %0d, expected %0d", r.name, cyc - acc_cyc, r.lat);
        end
      end
    end
  end

  function automatic logic [AW-1:0] idx_of(input logic [31:0] ip);
    logic [31:0] sh;
    sh = ip >> 8;
    return ip[AW-1:0] ^ sh[AW-1:0];
  endfunction

  function automatic logic [W-1:0] entry_of(input logic [31:0] ip, input logic [47:0] dst,
                                            input logic [47:0] src);
    logic [W-1:0] e;
    e = '0;
    e[255]     = 1'b1;
    e[223:192] = ip;
    e[191:144] = dst;
    e[143:96]  = src;
    return e;
  endfunction

  function automatic logic [AW:0] exp_count();
    return COUNT_EN ? (AW+1)'(cnt_model) : '0;
  endfunction

  task automatic push_resp(input logic [2:0] status, input int lat, input string name);
    resp_t r;
    r.status = status;
    r.lat    = lat;
    r.name   = name;
    resp_q.push_back(r);
  endtask

  task automatic push_write(input logic [AW-1:0] addr, input logic [W-1:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wr_q.push_back(w);
  endtask

  task automatic issue(input logic [1:0] op, input logic frc, input logic [31:0] ip,
                       input logic [47:0] dst, input logic [47:0] src);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_force   = frc;
    cmd_ip      = ip;
    cmd_dst_mac = dst;
    cmd_src_mac = src;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((resp_q.size() != 0 || !cmd_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: pending responses=%0d", name, resp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks += 8;
    if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL reset cmd_ready: got %b, expected 1", cmd_ready); end
    if (resp_done !== 1'b0)   begin errors++; $display("FAIL reset resp_done: got %b, expected 0", resp_done); end
    if (resp_status !== 3'd0) begin errors++; $display("FAIL reset resp_status: got %0d, expected 0", resp_status); end
    if (bram_en_a !== 1'b0)   begin errors++; $display("FAIL reset bram_en_a: got %b, expected 0", bram_en_a); end
    if (bram_we_a !== 1'b0)   begin errors++; $display("FAIL reset bram_we_a: got %b, expected 0", bram_we_a); end
    if (bram_addr_a !== '0)   begin errors++; $display("FAIL reset bram_addr_a: got %h, expected 0", bram_addr_a); end
    if (bram_din_a !== '0)    begin errors++; $display("FAIL reset bram_din_a: got %h, expected 0", bram_din_a); end
    if (entry_count !== '0)   begin errors++; $display("FAIL reset entry_count: got %0d, expected 0", entry_count); end
  endtask

  task automatic test_delete_empty();
    push_resp(3'd5, 3, "delete_empty");
    issue(2'd1, 1'b0, 32'hC0A80105, 48'h0, 48'h0);
    wait_done("delete_empty");
  endtask

  task automatic test_insert_new();
    push_write(11'h104, entry_of(32'hC0A80105, 48'h001122334455, 48'h66778899AABB));
    push_resp(3'd0, 4, "insert_new");
    issue(2'd0, 1'b0, 32'hC0A80105, 48'h001122334455, 48'h66778899AABB);
    wait_done("insert_new");
    cnt_model++;
    checks++;
    if (entry_count !== exp_count()) begin
      errors++;
      $display("FAIL insert_new entry_count: got %0d, expected %0d", entry_count, exp_count());
    end
  endtask

  task automatic test_collision();
    push_resp(3'd2, 3, "collision");
    issue(2'd0, 1'b0, 32'hC0B80105, 48'h0A0B0C0D0E0F, 48'h102030405060);
    wait_done("collision");
    push_write(11'h104, entry_of(32'hC0B80105, 48'h0A0B0C0D0E0F, 48'h102030405060));
    push_resp(3'd3, 4, "evict");
    issue(2'd0, 1'b1, 32'hC0B80105, 48'h0A0B0C0D0E0F, 48'h102030405060);
    wait_done("evict");
    checks += 2;
    if (mem[11'h104][223:192] !== 32'hC0B80105) begin
      errors++;
      $display("FAIL evict ip_field: got %h, expected c0b80105", mem[11'h104][223:192]);
    end
    if (entry_count !== exp_count()) begin
      errors++;
      $display("FAIL evict entry_count: got %0d, expected %0d", entry_count, exp_count());
    end
  endtask

  task automatic test_update();
    push_write(11'h104, entry_of(32'hC0A80105, 48'h001122334455, 48'h66778899AABB));
    push_resp(3'd3, 4, "evict_back");
    issue(2'd0, 1'b1, 32'hC0A80105, 48'h001122334455, 48'h66778899AABB);
    wait_done("evict_back");
    push_write(11'h104, entry_of(32'hC0A80105, 48'hAABBCCDDEEFF, 48'h66778899AABB));
    push_resp(3'd1, 4, "update");
    issue(2'd0, 1'b0, 32'hC0A80105, 48'hAABBCCDDEEFF, 48'h66778899AABB);
    wait_done("update");
    checks++;
    if (entry_count !== exp_count()) begin
      errors++;
      $display("FAIL update entry_count: got %0d, expected %0d", entry_count, exp_count());
    end
  endtask

  task automatic test_delete();
    push_resp(3'd5, 3, "delete_mismatch");
    issue(2'd1, 1'b0, 32'hC0B80105, 48'h0, 48'h0);
    wait_done("delete_mismatch");
    push_write(11'h104, '0);
    push_resp(3'd4, 4, "delete_hit");
    issue(2'd1, 1'b0, 32'hC0A80105, 48'h0, 48'h0);
    wait_done("delete_hit");
    cnt_model--;
    checks += 2;
    if (mem[11'h104] !== '0) begin
      errors++;
      $display("FAIL delete slot: got %h, expected 0", mem[11'h104]);
    end
    if (entry_count !== exp_count()) begin
      errors++;
      $display("FAIL delete entry_count: got %0d, expected %0d", entry_count, exp_count());
    end
  endtask

  task automatic test_bad_op();
    push_resp(3'd6, 1, "bad_op");
    issue(2'd3, 1'b0, 32'h12345678, 48'h0, 48'h0);
    wait_done("bad_op");
  endtask

  // A second command held on cmd_valid while busy must not be taken.
  task automatic test_busy_ignore();
    int n;
    push_write(idx_of(32'h0A000001), entry_of(32'h0A000001, 48'h111111111111, 48'h222222222222));
    push_resp(3'd0, 4, "busy_first");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_force = 1'b0; cmd_ip = 32'h0A000001;
    cmd_dst_mac = 48'h111111111111; cmd_src_mac = 48'h222222222222;
    @(negedge clk);
    cmd_ip = 32'h0B000202; cmd_dst_mac = 48'h333333333333;
    n = 0;
    while (!resp_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL timeout busy_first: no resp_done");
    end
    repeat (6) @(negedge clk);
    cnt_model++;
    checks += 2;
    if (mem[idx_of(32'h0B000202)] !== '0) begin
      errors++;
      $display("FAIL busy_ignored slot: got %h, expected 0", mem[idx_of(32'h0B000202)]);
    end
    if (entry_count !== exp_count()) begin
      errors++;
      $display("FAIL busy entry_count: got %0d, expected %0d", entry_count, exp_count());
    end
  endtask

  task automatic test_clear_all();
    for (int a = 0; a < (1 << AW); a++) push_write(AW'(a), '0);
    push_resp(3'd0, (1 << AW) + 1, "clear_all");
    issue(2'd2, 1'b0, 32'h0, 48'h0, 48'h0);
    wait_done("clear_all");
    cnt_model = 0;
    checks += 2;
    if (mem[idx_of(32'h0A000001)] !== '0) begin
      errors++;
      $display("FAIL clear slot: got %h, expected 0", mem[idx_of(32'h0A000001)]);
    end
    if (entry_count !== exp_count()) begin
      errors++;
      $display("FAIL clear entry_count: got %0d, expected %0d", entry_count, exp_count());
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    push_write(11'h104, entry_of(32'hC0A80105, 48'h001122334455, 48'h66778899AABB));
    push_resp(3'd0, 4, "reinsert");
    issue(2'd0, 1'b0, 32'hC0A80105, 48'h001122334455, 48'h66778899AABB);
    wait_done("reinsert");
    for (int a = 0; a <= 16; a++) push_write(AW'(a), '0);
    issue(2'd2, 1'b0, 32'h0, 48'h0, 48'h0);
    n = 0;
    while (bram_addr_a !== 11'h010 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1 rstn = 1'b0;
    #1;
    cnt_model = 0;
    checks += 7;
    if (n >= 100)            begin errors++; $display("FAIL timeout mid_clear: addr %h never reached 010", bram_addr_a); end
    if (bram_en_a !== 1'b0)  begin errors++; $display("FAIL mid_clear bram_en_a: got %b, expected 0", bram_en_a); end
    if (bram_we_a !== 1'b0)  begin errors++; $display("FAIL mid_clear bram_we_a: got %b, expected 0", bram_we_a); end
    if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL mid_clear cmd_ready: got %b, expected 1", cmd_ready); end
    if (entry_count !== '0)  begin errors++; $display("FAIL mid_clear entry_count: got %0d, expected 0", entry_count); end
    if (wr_q.size() != 0)    begin errors++; $display("FAIL mid_clear writes_missing: got %0d pending, expected 0", wr_q.size()); end
    if (mem[11'h104][255] !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear untouched_slot: got valid=%b, expected 1", mem[11'h104][255]);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_delete_empty();
    test_insert_new();
    test_collision();
    test_update();
    test_delete();
    test_bad_op();
    test_busy_ignore();
    test_clear_all();
    test_reset_mid_clear();
    checks += 2;
    if (resp_q.size() != 0) begin errors++; $display("FAIL leftover_resp: got %0d, expected 0", resp_q.size()); end
    if (wr_q.size() != 0)   begin errors++; $display("FAIL leftover_write: got %0d, expected 0", wr_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
